// File: rtl/w_sram_fetch.sv
// Weight-fetch controller: streams a contiguous run of SRAM weight words to the weight-load path.
// Latency: start in cycle 0, first read in cycle 1, first w_valid in cycle 3, then one word per cycle.
// Backpressure: w_ready low stalls the head word; a 2-entry skid FIFO plus read credits stall reads.
//
// Ports:
//   CLK, RESET_N             clock shared with the SRAM, async active-low reset
//   start/base_addr/len      command, sampled only in IDLE when no done pulse is showing
//   sram_cen/wen/a, sram_q   synchronous-read SRAM port (read-only, one-cycle latency)
//   w_data/w_valid/w_ready   weight stream (transfer = w_valid & w_ready)
//   busy/done/err            status: busy from accept to done, done/err are one-cycle pulses
module w_sram_fetch #(
  parameter int NUM = 108,
  parameter int AW  = 7,
  parameter int DW  = 32
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  input  logic [DW-1:0] sram_q,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  input  logic          w_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] NUM_W = (AW+1)'(NUM);

  state_t        state_q;
  logic [AW-1:0] base_q, len_q, a_q;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] tx_cnt_q, tx_cnt_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          inflight_q, valid_q, busy_q, done_q, err_q;

  logic          pop, push, credit_ok, rd_issue;
  logic          can_start, cmd_ok, start_acc, start_rej;
  logic [AW:0]   end_addr;
  logic [AW-1:0] rd_addr;

  // Command check at AW+1 bits so base+len cannot overflow.
  assign end_addr  = {1'b0, base_addr} + {1'b0, len};
  assign cmd_ok    = (len != '0) && ({1'b0, len} <= NUM_W) && (end_addr <= NUM_W);
  // A start coinciding with the done pulse is ignored even though the FSM is already IDLE.
  assign can_start = (state_q == IDLE) && !done_q;
  assign start_acc = start && can_start && cmd_ok;
  assign start_rej = start && can_start && !cmd_ok;

  assign pop  = valid_q & w_ready;
  assign push = inflight_q;   // sram_q carries the word read last cycle

  // Read credit: words held + word in flight - word leaving now must stay below 2.
  // Depends on this cycle's w_ready, so the read strobe is combinational.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign rd_issue  = (state_q == FETCH) && credit_ok;
  assign rd_addr   = base_q + rd_cnt_q;

  assign sram_cen = ~rd_issue;
  assign sram_wen = 1'b1;
  assign sram_a   = rd_issue ? rd_addr : a_q;

  assign w_data  = head_q;
  assign w_valid = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    rd_cnt_d = start_acc ? '0 : rd_cnt_q + {{(AW-1){1'b0}}, rd_issue};
    tx_cnt_d = start_acc ? '0 : tx_cnt_q + {{(AW-1){1'b0}}, pop};
  end

  // Skid FIFO held as head/tail registers; the head drives w_data directly.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = sram_q;
        else               tail_d = sram_q;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = sram_q;
        end else begin
          head_d = sram_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      a_q        <= '0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= (occ_d != 2'd0);
      inflight_q <= rd_issue;
      if (rd_issue) a_q <= rd_addr;
      err_q  <= start_rej;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            base_q  <= base_addr;
            len_q   <= len;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (rd_cnt_d == len_q) state_q <= DRAIN;
        end
        DRAIN: begin
          // All words delivered implies nothing in flight and an empty FIFO.
          if ((tx_cnt_d == len_q) && (occ_d == 2'd0)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The read credit must keep pushes away from a full FIFO.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET_N)
                                  !(push && (occ_q == 2'd2) && !pop));

endmodule

// File: tb/tb_w_sram_fetch.sv
module tb_w_sram_fetch;
  localparam int NUM = 108;
  localparam int AW  = 7;
  localparam int DW  = 32;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len = '0;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_q = '0;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic          busy, done, err;

  w_sram_fetch #(.NUM(NUM), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .base_addr(base_addr), .len(len),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_q(sram_q),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read SRAM model; q holds until the next read.
  logic [DW-1:0] mem [0:127];
  always @(posedge CLK) if (!sram_cen) sram_q <= mem[sram_a];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cen"},   sram_cen, 1);
    chk({tag, "_wen"},   sram_wen, 1);
    chk({tag, "_a"},     sram_a,   0);
    chk({tag, "_valid"}, w_valid,  0);
    chk({tag, "_data"},  w_data,   0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_err"},   err,      0);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
  endtask

  // rmode: 0 = ready always, 1 = ready pattern 1,0,0 repeating from cycle 3, 2 = random ready.
  // busy_start_at: cycle for an extra start while busy (0 = none).
  // start_on_done: drive a legal start during the done cycle.
  // rst_at: cycle at which reset is asserted and the run abandoned (0 = none).
  task automatic run_cmd(input int b, input int l, input int rmode, input int busy_start_at,
                         input bit start_on_done, input int rst_at);
    bit ok;
    int reads, pops, done_cnt, done_cyc, err_cnt, err_cyc, max_out, busy_seen, bound;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    ok = (l >= 1) && (l <= NUM) && (b + l <= NUM);
    reads = 0; pops = 0; done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    max_out = 0; busy_seen = 0; prev_stall = 0; prev_data = '0;
    bound = ok ? 6 * l + 20 : 4;

    @(posedge CLK); #1;
    start = 1'b1; base_addr = AW'(b); len = AW'(l); w_ready = 1'b1;
    @(posedge CLK); #1;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      start = (cyc == busy_start_at);
      if (start) begin base_addr = 7'd50; len = 7'd3; end
      case (rmode)
        0:       w_ready = 1'b1;
        1:       w_ready = (cyc % 3 == 0);
        default: w_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == rst_at) begin
        RESET_N = 1'b0;
        #1;
        chk_reset("midrst");
        start = 1'b0;
        return;
      end
      @(negedge CLK);
      if (busy) busy_seen++;
      if (cyc == 1) chk("busy_c1", busy, ok);
      if (prev_stall) begin
        chk("stall_valid", w_valid, 1);
        chk("stall_data", w_data, prev_data);
      end
      prev_stall = w_valid && !w_ready;
      prev_data  = w_data;
      if (!sram_cen) begin
        if (ok) chk("rd_addr", sram_a, b + reads);
        reads++;
      end
      if (w_valid && w_ready) begin
        if (ok && pops < l) chk("w_data", w_data, mem[b + pops]);
        if (rmode == 0) chk("w_cycle", cyc, pops + 3);
        pops++;
      end
      if (reads - pops > max_out) max_out = reads - pops;
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          chk("busy_at_done", busy, 0);
          if (start_on_done) begin start = 1'b1; base_addr = 7'd0; len = 7'd2; end
        end
      end
      if (start_on_done && done_cyc > 0 && cyc > done_cyc) chk("start_at_done_busy", busy, 0);
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
      @(posedge CLK); #1;
    end
    start = 1'b0;

    if (ok) begin
      chk("done_count", done_cnt, 1);
      chk("read_count", reads, l);
      chk("word_count", pops, l);
      chk("no_err", err_cnt, 0);
      chk("outstanding_le2", (max_out <= 2), 1);
      if (rmode == 0) chk("done_cycle", done_cyc, l + 3);
    end else begin
      chk("err_cycle", err_cyc, 1);
      chk("err_count", err_cnt, 1);
      chk("rej_reads", reads, 0);
      chk("rej_busy", busy_seen, 0);
      chk("rej_done", done_cnt, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_pattern();
    #12;
    chk_reset("por");
    @(negedge CLK);
    RESET_N = 1'b1;

    // Basic run
    run_cmd(10, 4, 0, 0, 0, 0);
    // Backpressure
    run_cmd(20, 8, 1, 0, 0, 0);
    // Boundary: last address 107 accepted, one past rejected
    run_cmd(100, 8, 0, 0, 0, 0);
    run_cmd(101, 8, 0, 0, 0, 0);
    // Length extremes
    run_cmd(5, 1, 0, 0, 0, 0);
    run_cmd(5, 0, 0, 0, 0, 0);
    run_cmd(0, 108, 0, 0, 0, 0);
    // Reset mid-operation, then a fresh basic run
    run_cmd(30, 20, 0, 0, 0, 5);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_hold_done", done, 0);
      chk("rst_hold_busy", busy, 0);
    end
    RESET_N = 1'b1;
    run_cmd(10, 4, 0, 0, 0, 0);
    // Start while busy, and start during the done cycle
    run_cmd(40, 6, 0, 4, 0, 0);
    run_cmd(60, 3, 0, 0, 1, 0);
    run_cmd(40, 6, 1, 4, 1, 0);

    // Randomized commands, contents and backpressure
    for (int k = 0; k < 20; k++) begin
      fill_random();
      run_cmd($urandom_range(0, 110), $urandom_range(0, 40), 2, 0, 0, 0);
    end
    fill_random();
    run_cmd(0, 108, 2, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/w_sram_fetch.md
# w_sram_fetch

Weight-fetch controller sitting directly downstream of the 32-bit weight SRAM (108 words, 7-bit address, synchronous read). On a `start` command it reads a contiguous run of weight words out of the SRAM and presents them to the systolic-array weight-load path as a valid/ready stream. It absorbs the SRAM's one-cycle read latency and downstream backpressure with a 2-entry skid FIFO, so no word is lost or duplicated.

## Interface
Parameters:
- `NUM`, 108: SRAM depth in words; legal addresses are 0..NUM-1.
- `AW`, 7: SRAM address width.
- `DW`, 32: word width.

Ports:
- `CLK`  in  1  rising-edge clock shared with the SRAM.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  AW  first SRAM address; sampled with `start`.
- `len`  in  AW  number of words to fetch, 1..NUM; sampled with `start`.
- `sram_cen`  out  1  SRAM chip enable, active low.
- `sram_wen`  out  1  SRAM write enable; held at 1 (read-only).
- `sram_a`  out  AW  SRAM address.
- `sram_q`  in  DW  SRAM read data; valid the cycle after a read request and held until the next read.
- `w_data`  out  DW  streamed weight word.
- `w_valid`  out  1  `w_data` is valid.
- `w_ready`  in  1  the consumer accepts the word this cycle (transfer = `w_valid` & `w_ready`).
- `busy`  out  1  high from an accepted start until `done`.
- `done`  out  1  one-cycle pulse after the last word transfers.
- `err`  out  1  one-cycle pulse when a start is rejected.

## Operation
- State machine states are IDLE, FETCH and DRAIN.
- IDLE:
  - `start`=1 with 1 ≤ `len` ≤ NUM and `base_addr`+`len` ≤ NUM (computed at AW+1 bits): latch the command, clear the counters and go to FETCH.
  - Otherwise `start`=1 pulses `err` on the next cycle and the block stays in IDLE.
- `start` is ignored outside IDLE.
- FETCH:
  - Issue one read per cycle (`sram_cen`=0, `sram_a`=`base_addr`+`rd_cnt`) whenever `occ` − `pop` + `inflight` < 2.
    - `occ` is the FIFO occupancy (0..2).
    - `pop` is this cycle's transfer.
    - `inflight` is 1 when a read was issued in the previous cycle.
  - `rd_cnt` increments per read. After `rd_cnt` reaches `len`, go to DRAIN.
- DRAIN: issue no reads. When `inflight`=0, `occ`=0 and every word has been transferred, pulse `done` and return to IDLE.
- The cycle after each issued read, push `sram_q` into the FIFO.
- By construction the credit rule never lets the FIFO overflow. A push into a full FIFO is a design error; flag it with an assertion.
- `w_valid` = (`occ` ≠ 0) and `w_data` = FIFO head, both driven from registers.
- `sram_cen`=1 in every cycle without a read. `sram_a` holds its last value when idle.
- The address never wraps, because the start check guarantees the last address is NUM-1 or less.

## Timing
- Reset values (asynchronous, RESET_N=0):
  - `sram_cen`=1, `sram_wen`=1, `sram_a`=0.
  - `w_valid`=0, `w_data`=0.
  - `busy`=0, `done`=0, `err`=0.
  - State is IDLE and all counters are 0.
- Reset asserted mid-transfer discards the command and the FIFO contents. No `done` is produced.
- Cycle numbering: `start` is high in cycle 0.
  - Cycle 1: `busy`=1, first read issued (`sram_a`=`base_addr`).
  - Cycle 2: `sram_q` holds the first word and it is pushed.
  - Cycle 3: `w_valid`=1.
- With `w_ready` held at 1:
  - One word per cycle.
  - The last word is valid in cycle `len`+2.
  - `done`=1 in cycle `len`+3, and `busy` falls in that same cycle.
- While `w_valid`=1 and `w_ready`=0, `w_data` is stable. At most 2 words are buffered and reads stall.
- Reads resume in the cycle the first transfer occurs after the stall, with no bubble beyond the credit rule.
- `start` arriving in the same cycle as `done` is ignored. A new command needs `start` in a cycle where `busy`=0.
- `err` rises in cycle 1 for a rejected start, and `busy` stays 0.

## Test plan
- Basic run:
  - Stimulus: SRAM preloaded with mem[i]=0xA5000000+i; `base_addr`=10, `len`=4; `w_ready`=1.
  - Response: `w_data` 0xA500000A..0xA500000D in cycles 3..6; `done` in cycle 7; exactly 4 reads with `sram_cen`=0.
- Backpressure:
  - Stimulus: `len`=8; `w_ready` toggles 1,0,0,1,...
  - Response: all 8 words in order, none duplicated; at most 2 reads outstanding past the last pop; `w_data` stable while stalled.
- Boundary:
  - Stimulus: `base_addr`=100, `len`=8.
  - Response: last address 107, accepted.
  - Stimulus: `base_addr`=101, `len`=8.
  - Response: `err` pulse in cycle 1, no SRAM access.
- Len extremes:
  - Stimulus: `len`=1.
  - Response: one word in cycle 3, `done` in cycle 4.
  - Stimulus: `len`=0.
  - Response: `err` pulse.
  - Stimulus: `base_addr`=0, `len`=108.
  - Response: 108 words, `done` in cycle 111.
- Reset mid-op:
  - Stimulus: assert `RESET_N`=0 in cycle 5 of a `len`=20 run.
  - Response: outputs go immediately to their reset values; no `done`; a fresh start afterwards behaves exactly like the basic run.
- Start while busy:
  - Stimulus: second `start` in cycle 4.
  - Response: ignored; one `done` only; the word count equals the first command's `len`.
